// File: rtl/permutation_round_ctrl_pkg.sv
// Shared types for the ASCON permutation sequencer: FSM encoding, 320-bit state, round counts.
// Round indices run 0..11; a short permutation starts late so that it always ends on index 11.
package permutation_round_ctrl_pkg;

  localparam int ROUNDS_PA = 12;
  localparam int ROUNDS_PB = 6;
  localparam logic [3:0] LAST_ROUND = 4'd11;

  typedef logic [4:0][63:0] type_state;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAPT = 2'd2,
    HOLD = 2'd3
  } type_round_ctrl_fsm;

  function automatic logic [3:0] first_round(input int rounds);
    return 4'(ROUNDS_PA - rounds);
  endfunction

endpackage

// File: rtl/permutation_round_ctrl_if.sv
// Control, permutation-core and result handshake signals of the round sequencer.
// slave = sequencer side, master = environment driving start/ready and returning core state.
interface permutation_round_ctrl_if;
  import permutation_round_ctrl_pkg::*;

  logic       start_i;
  logic       mode_i;
  type_state  perm_state_i;
  logic       perm_enable_o;
  logic       perm_input_mode_o;
  logic [3:0] perm_round_o;
  logic       busy_o;
  logic       done_o;
  type_state  result_o;
  logic       result_valid_o;
  logic       result_ready_i;

  modport slave (
    input  start_i,
    input  mode_i,
    input  perm_state_i,
    input  result_ready_i,
    output perm_enable_o,
    output perm_input_mode_o,
    output perm_round_o,
    output busy_o,
    output done_o,
    output result_o,
    output result_valid_o
  );

  modport master (
    output start_i,
    output mode_i,
    output perm_state_i,
    output result_ready_i,
    input  perm_enable_o,
    input  perm_input_mode_o,
    input  perm_round_o,
    input  busy_o,
    input  done_o,
    input  result_o,
    input  result_valid_o
  );

endinterface

// File: rtl/permutation_round_ctrl.sv
// Sequences one ASCON p^a/p^b through permutation_simple; result valid N+1 cycles after accept.
// Result held in HOLD until result_ready_i; start_i ignored while busy, no queuing.
module permutation_round_ctrl
  import permutation_round_ctrl_pkg::*;
#(
  parameter int ROUNDS_A = ROUNDS_PA,
  parameter int ROUNDS_B = ROUNDS_PB
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  permutation_round_ctrl_if.slave  ctrl
);

  generate
    if (ROUNDS_A < 1 || ROUNDS_A > ROUNDS_PA) begin : g_bad_rounds_a
      $fatal(1, "permutation_round_ctrl: ROUNDS_A out of range 1..12");
    end
    if (ROUNDS_B < 1 || ROUNDS_B > ROUNDS_PA) begin : g_bad_rounds_b
      $fatal(1, "permutation_round_ctrl: ROUNDS_B out of range 1..12");
    end
  endgenerate

  localparam logic [3:0] FIRST_A = first_round(ROUNDS_A);
  localparam logic [3:0] FIRST_B = first_round(ROUNDS_B);

  type_round_ctrl_fsm state_q, state_d;
  logic [3:0]         round_q, round_d;
  logic               input_mode_q, input_mode_d;
  logic               enable_q, enable_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               valid_q, valid_d;
  type_state          result_q, result_d;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      round_q      <= '0;
      input_mode_q <= 1'b0;
      enable_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      valid_q      <= 1'b0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      input_mode_q <= input_mode_d;
      enable_q     <= enable_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      valid_q      <= valid_d;
      result_q     <= result_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    input_mode_d = input_mode_q;
    result_d     = result_q;

    case (state_q)
      IDLE: begin
        if (ctrl.start_i) begin
          // The starting index alone carries the mode: both lengths finish at index 11.
          state_d      = RUN;
          round_d      = ctrl.mode_i ? FIRST_B : FIRST_A;
          input_mode_d = 1'b0;
        end
      end
      RUN: begin
        input_mode_d = 1'b1;
        if (round_q == LAST_ROUND) begin
          state_d = CAPT;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      CAPT: begin
        result_d = ctrl.perm_state_i;
        state_d  = HOLD;
      end
      HOLD: begin
        if (ctrl.result_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so every port leaves a flop.
    enable_d = (state_d == RUN);
    done_d   = (state_d == CAPT);
    valid_d  = (state_d == HOLD);
    busy_d   = (state_d != IDLE);
  end

  assign ctrl.perm_enable_o     = enable_q;
  assign ctrl.perm_input_mode_o = input_mode_q;
  assign ctrl.perm_round_o      = round_q;
  assign ctrl.busy_o            = busy_q;
  assign ctrl.done_o            = done_q;
  assign ctrl.result_o          = result_q;
  assign ctrl.result_valid_o    = valid_q;

endmodule

// File: tb/tb_permutation_round_ctrl.sv
// Bench for permutation_round_ctrl with a behavioural stand-in for permutation_simple
// and an independent ASCON reference for the expected p^a / p^b results.
module tb_permutation_round_ctrl;
  import permutation_round_ctrl_pkg::*;

  logic clock_i = 1'b0;
  logic reset_i = 1'b1;
  always #5 clock_i = ~clock_i;

  permutation_round_ctrl_if u_if ();

  permutation_round_ctrl #(
    .ROUNDS_A(12),
    .ROUNDS_B(6)
  ) dut (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .ctrl   (u_if)
  );

  int        n_checks = 0;
  int        n_errors = 0;
  type_state st_in;
  type_state exp_a;
  type_state exp_b;
  type_state pstate = '0;

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic type_state ascon_round(input type_state s, input logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    type_state o;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x2 = x2 ^ {56'h0, ~r, r};
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    o[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    o[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    o[2] = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    o[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    o[4] = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return o;
  endfunction

  function automatic type_state perm_ref(input type_state s, input int n);
    type_state t;
    t = s;
    for (int r = 12 - n; r < 12; r++) t = ascon_round(t, 4'(r));
    return t;
  endfunction

  // Stand-in for permutation_simple: one round per enabled cycle.
  always @(posedge clock_i) begin
    if (u_if.perm_enable_o)
      pstate <= ascon_round(u_if.perm_input_mode_o ? pstate : st_in, u_if.perm_round_o);
  end
  assign u_if.perm_state_i = pstate;

  task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic start_op(input logic mode);
    u_if.mode_i  = mode;
    u_if.start_i = 1'b1;
    tick();
    u_if.start_i = 1'b0;
    u_if.mode_i  = ~mode;
  endtask

  // Entered on the first RUN cycle; leaves the bench positioned in the first HOLD cycle.
  task automatic run_checks(input logic mode, input type_state exp);
    int n;
    int f;
    n = mode ? 6 : 12;
    f = 12 - n;
    for (int k = 0; k < n; k++) begin
      chk("run_en",    320'(u_if.perm_enable_o),     320'(1));
      chk("run_round", 320'(u_if.perm_round_o),      320'(f + k));
      chk("run_imode", 320'(u_if.perm_input_mode_o), 320'(k != 0));
      chk("run_busy",  320'(u_if.busy_o),            320'(1));
      chk("run_valid", 320'(u_if.result_valid_o),    320'(0));
      chk("run_done",  320'(u_if.done_o),            320'(0));
      tick();
    end
    chk("capt_done",  320'(u_if.done_o),         320'(1));
    chk("capt_en",    320'(u_if.perm_enable_o),  320'(0));
    chk("capt_valid", 320'(u_if.result_valid_o), 320'(0));
    chk("capt_round", 320'(u_if.perm_round_o),   320'(11));
    tick();
    chk("hold_valid",  320'(u_if.result_valid_o), 320'(1));
    chk("hold_result", u_if.result_o,             exp);
    chk("hold_done",   320'(u_if.done_o),         320'(0));
    chk("hold_busy",   320'(u_if.busy_o),         320'(1));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_en"},     320'(u_if.perm_enable_o),     320'(0));
    chk({tag, "_imode"},  320'(u_if.perm_input_mode_o), 320'(0));
    chk({tag, "_round"},  320'(u_if.perm_round_o),      320'(0));
    chk({tag, "_busy"},   320'(u_if.busy_o),            320'(0));
    chk({tag, "_done"},   320'(u_if.done_o),            320'(0));
    chk({tag, "_valid"},  320'(u_if.result_valid_o),    320'(0));
    chk({tag, "_result"}, u_if.result_o,                320'(0));
  endtask

  initial begin
    int starts[$];
    int n_valid;
    st_in[0] = 64'h00001000808C0001;
    st_in[1] = 64'h6CB10AD9CA912F80;
    st_in[2] = 64'h691AED630E81901F;
    st_in[3] = 64'h0C4C36A20853217C;
    st_in[4] = 64'h46487B3E06D9D7A8;
    exp_a = perm_ref(st_in, 12);
    exp_b = perm_ref(st_in, 6);

    u_if.start_i        = 1'b0;
    u_if.mode_i         = 1'b0;
    u_if.result_ready_i = 1'b0;
    reset_i = 1'b1;
    repeat (3) tick();
    chk_zero("reset");
    reset_i = 1'b0;
    tick();

    // p^a with ready high: HOLD lasts one cycle
    u_if.result_ready_i = 1'b1;
    start_op(1'b0);
    run_checks(1'b0, exp_a);
    tick();
    chk("pa_exit_valid", 320'(u_if.result_valid_o), 320'(0));
    chk("pa_exit_busy",  320'(u_if.busy_o),         320'(0));
    chk("pa_idle_round", 320'(u_if.perm_round_o),   320'(11));

    // p^b
    start_op(1'b1);
    run_checks(1'b1, exp_b);
    tick();
    chk("pb_exit_valid", 320'(u_if.result_valid_o), 320'(0));

    // Backpressure with start pulses that must be ignored
    u_if.result_ready_i = 1'b0;
    start_op(1'b0);
    run_checks(1'b0, exp_a);
    for (int i = 0; i < 20; i++) begin
      u_if.start_i = i[0];
      tick();
      chk("bp_valid",  320'(u_if.result_valid_o), 320'(1));
      chk("bp_result", u_if.result_o,             exp_a);
      chk("bp_busy",   320'(u_if.busy_o),         320'(1));
      chk("bp_en",     320'(u_if.perm_enable_o),  320'(0));
    end
    u_if.start_i        = 1'b0;
    u_if.result_ready_i = 1'b1;
    tick();
    chk("bp_exit_valid", 320'(u_if.result_valid_o), 320'(0));
    chk("bp_exit_busy",  320'(u_if.busy_o),         320'(0));
    tick();
    chk("bp_noqueue_busy", 320'(u_if.busy_o),        320'(0));
    chk("bp_noqueue_en",   320'(u_if.perm_enable_o), 320'(0));

    // Back-to-back p^a with start and ready tied high
    u_if.mode_i  = 1'b0;
    u_if.start_i = 1'b1;
    n_valid = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick();
      if (u_if.perm_enable_o && !u_if.perm_input_mode_o) starts.push_back(cyc);
      if (u_if.result_valid_o) begin
        n_valid++;
        chk("b2b_result", u_if.result_o, exp_a);
      end
    end
    u_if.start_i = 1'b0;
    chk("b2b_nstarts", 320'(starts.size()), 320'(3));
    chk("b2b_nvalid",  320'(n_valid),       320'(2));
    if (starts.size() == 3) begin
      chk("b2b_first",    320'(starts[0]),             320'(0));
      chk("b2b_spacing1", 320'(starts[1] - starts[0]), 320'(15));
      chk("b2b_spacing2", 320'(starts[2] - starts[1]), 320'(15));
    end
    repeat (10) tick();
    chk("b2b_drain_busy", 320'(u_if.busy_o), 320'(0));

    // Reset in the 5th RUN cycle
    start_op(1'b0);
    repeat (4) tick();
    chk("rst_run5_round", 320'(u_if.perm_round_o), 320'(4));
    reset_i = 1'b1;
    tick();
    chk_zero("rst_run");
    reset_i = 1'b0;
    n_valid = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (u_if.done_o || u_if.result_valid_o || u_if.busy_o) n_valid++;
    end
    chk("rst_quiet", 320'(n_valid), 320'(0));
    start_op(1'b1);
    run_checks(1'b1, exp_b);
    tick();

    // start and ready together in the HOLD exit cycle
    u_if.result_ready_i = 1'b0;
    start_op(1'b0);
    run_checks(1'b0, exp_a);
    u_if.mode_i         = 1'b0;
    u_if.start_i        = 1'b1;
    u_if.result_ready_i = 1'b1;
    tick();
    chk("hx_idle_busy",  320'(u_if.busy_o),         320'(0));
    chk("hx_idle_en",    320'(u_if.perm_enable_o),  320'(0));
    chk("hx_idle_valid", 320'(u_if.result_valid_o), 320'(0));
    tick();
    u_if.start_i = 1'b0;
    u_if.mode_i  = 1'b1;
    run_checks(1'b0, exp_a);
    tick();
    chk("hx_final_busy", 320'(u_if.busy_o), 320'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
